damage_scan_engine: RTL and testbench
=====================================

// Module: damage_scan_engine
// PURPOSE
//   Parametrised per-frame damage engine; generalises the fixed 8-slot scanner.
//   On a start pulse, walks NUM_SLOTS bullet slots one per clock and reads each
//   slot's collision flag and colour through an index/response interface.
//   Applies the colour rule against player motion, accumulates damage and hit
//   count, then publishes both with a one-cycle done pulse. Sits between the
//   bullet table and the player HP logic.
// PARAMETERS
//   NUM_SLOTS     8   number of bullet slots scanned per frame (>=1)
//   IDX_W         3   slot index width; 2**IDX_W >= NUM_SLOTS
//   DMG_W         8   width of damage result and accumulator
//   ATTACK_POWER  50  damage added per qualifying hit; must fit in DMG_W
//   CNT_W         4   hit-count width; 2**CNT_W > NUM_SLOTS
// PORTS
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   start          in   1      1-cycle synchronous request; starts a scan
//   player_moving  in   1      player moved this frame
//   slot_collide   in   1      collision flag of slot addressed by slot_idx
//   slot_color     in   2      colour of addressed slot: 0 white,1 blue,2 orange,3 none
//   slot_idx       out  IDX_W  slot currently addressed (registered)
//   busy           out  1      high while scanning
//   done           out  1      1-cycle pulse: damage/hit_count updated
//   damage         out  DMG_W  total damage of last completed scan
//   hit_count      out  CNT_W  qualifying hits of last completed scan
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; slot_idx, busy, done, damage,
//     hit_count, accumulators all 0.
//   FSM IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: start=1 -> clear acc/count, slot_idx=0, busy=1, go SCAN.
//   SCAN: each clock samples slot_collide/slot_color for current slot_idx
//     (combinational response, same cycle). Hit = collide && (color==0 ||
//     (color==1 && player_moving) || (color==2 && !player_moving)); color 3
//     never hits. Hit -> acc += ATTACK_POWER, count += 1.
//     slot_idx < NUM_SLOTS-1 -> slot_idx+1; else register damage=acc_next,
//     hit_count=count_next, done=1, busy=0, slot_idx=0, go DONE.
//   DONE: lasts exactly one cycle; done deasserts next clock. start here is
//     accepted as in IDLE (back-to-back scans); else -> IDLE.
//   Latency: start sampled at edge E -> done high after edge E+NUM_SLOTS+1,
//     i.e. NUM_SLOTS scan cycles plus one.
//   start while busy: ignored, scan continues unaffected.
//   damage/hit_count hold last result throughout a scan; change only with done.
//   player_moving sampled every scan cycle (not latched at start).
//   Arithmetic: acc DMG_W+1 bits internally; overflow per CONFIGURATION.
//   rst_n low mid-scan: abort, no done, outputs to reset values.
// CONFIGURATION
//   DAMAGE_SATURATE_EN defined: accumulator clamps at 2**DMG_W-1; further hits
//     still increment hit_count.
//   Not defined: accumulator wraps modulo 2**DMG_W.
// TESTING
//   1 Reset, no start for 20 clk -> busy=0, done=0, damage=0, slot_idx=0.
//   2 start; slots 2,5 collide white; defaults -> done exactly 9 clk after
//     start edge, damage=100, hit_count=2, slot_idx seen 0..7 in order.
//   3 All slots collide blue, player_moving=0 -> damage=0, hit_count=0;
//     repeat with orange -> damage=0 hits 0 only if player_moving=1.
//   4 All 8 slots collide white: SATURATE_EN -> damage=255, hit_count=8;
//     without -> damage=144 (400 mod 256), hit_count=8.
//   5 start pulsed again at scan cycle 3 -> ignored, single done at cycle 9;
//     start on done cycle -> second scan begins, second done 9 clk later.
//   6 rst_n low at scan cycle 4 -> no done, damage=0, busy=0 immediately.

Source files
------------

// File: rtl/damage_scan_engine.sv
// damage_scan_engine: per-frame bullet damage scanner.
// Walks NUM_SLOTS bullet slots one per clock, applies the colour/motion hit
// rule, accumulates damage and hit count, then publishes both with a
// one-cycle done pulse.
// Optional build macro: DAMAGE_SATURATE_EN -- damage accumulator clamps at
// 2**DMG_W-1 instead of wrapping modulo 2**DMG_W.
module damage_scan_engine #(
  parameter int unsigned NUM_SLOTS    = 8,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned DMG_W        = 8,
  parameter int unsigned ATTACK_POWER = 50,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             player_moving,
  input  logic             slot_collide,
  input  logic [1:0]       slot_color,
  output logic [IDX_W-1:0] slot_idx,
  output logic             busy,
  output logic             done,
  output logic [DMG_W-1:0] damage,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned      ACC_W    = DMG_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [ACC_W-1:0] AP_EXT   = ACC_W'(ATTACK_POWER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DMG_W-1:0] damage_q, damage_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [DMG_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hit_c;
  logic [ACC_W-1:0] acc_sum_c;
  logic [DMG_W-1:0] acc_add_c;

  // Hit rule: white always, blue only when moving, orange only when still.
  always_comb begin
    hit_c = 1'b0;
    if (slot_collide) begin
      case (slot_color)
        2'd0:    hit_c = 1'b1;
        2'd1:    hit_c = player_moving;
        2'd2:    hit_c = ~player_moving;
        default: hit_c = 1'b0;
      endcase
    end
  end

  // Accumulator add with one guard bit; overflow handling is a build option.
  always_comb begin
    acc_sum_c = {1'b0, acc_q} + AP_EXT;
`ifdef DAMAGE_SATURATE_EN
    acc_add_c = acc_sum_c[DMG_W] ? {DMG_W{1'b1}} : acc_sum_c[DMG_W-1:0];
`else
    acc_add_c = acc_sum_c[DMG_W-1:0];
`endif
  end

  // Next-state and output logic. The final slot's totals land in acc/cnt,
  // and the DONE cycle publishes them so done appears NUM_SLOTS+1 clocks
  // after start is sampled.
  always_comb begin
    state_d     = state_q;
    slot_idx_d  = slot_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    damage_d    = damage_q;
    hit_count_d = hit_count_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d      = '0;
          cnt_d      = '0;
          slot_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (hit_c) begin
          acc_d = acc_add_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (slot_idx_q < LAST_IDX) begin
          slot_idx_d = slot_idx_q + IDX_W'(1);
        end else begin
          slot_idx_d = '0;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        damage_d    = acc_q;
        hit_count_d = cnt_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        slot_idx_d = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      damage_q    <= '0;
      hit_count_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_idx_q  <= slot_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      damage_q    <= damage_d;
      hit_count_q <= hit_count_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign slot_idx  = slot_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign damage    = damage_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_damage_scan_engine.sv
// Bench for damage_scan_engine: frame-level scoring model plus per-cycle
// timeline, checked every negedge, with literal pins on key results.
module tb_damage_scan_engine;

  localparam int unsigned N     = 8;
  localparam int unsigned AP    = 50;
  localparam int unsigned DMG_W = 8;
  localparam int          LAT   = N + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       slot_collide;
  logic [1:0] slot_color;
  logic       player_moving;
  logic [2:0] slot_idx;
  logic       busy;
  logic       done;
  logic [7:0] damage;
  logic [3:0] hit_count;

  logic       f_collide [N];
  logic [1:0] f_color   [N];
  logic       f_moving  [N];

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model timeline: m_cyc = 0 idle, 1..N scanning slot m_cyc-1, N+1 wrap-up.
  int m_cyc    = 0;
  int m_done   = 0;
  int m_damage = 0;
  int m_hits   = 0;

  int lat;

  damage_scan_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .player_moving(player_moving),
    .slot_collide (slot_collide),
    .slot_color   (slot_color),
    .slot_idx     (slot_idx),
    .busy         (busy),
    .done         (done),
    .damage       (damage),
    .hit_count    (hit_count)
  );

  always #5 clk = ~clk;

  // Bullet table and motion responding combinationally to the addressed slot.
  assign slot_collide  = f_collide[slot_idx];
  assign slot_color    = f_color[slot_idx];
  assign player_moving = f_moving[slot_idx];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Frame score straight from the rules: count qualifying hits, then scale.
  task automatic score(output int dmg, output int hits);
    int raw;
    hits = 0;
    for (int i = 0; i < N; i++) begin
      if (f_collide[i] && (f_color[i] == 2'd0 ||
                           (f_color[i] == 2'd1 && f_moving[i]) ||
                           (f_color[i] == 2'd2 && !f_moving[i])))
        hits++;
    end
    raw = hits * AP;
`ifdef DAMAGE_SATURATE_EN
    dmg = (raw > (2**DMG_W - 1)) ? (2**DMG_W - 1) : raw;
`else
    dmg = raw % (2**DMG_W);
`endif
  endtask

  // Model timeline advance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_done = 0; m_damage = 0; m_hits = 0;
    end else begin
      m_done = 0;
      if (m_cyc == 0) begin
        if (start) m_cyc = 1;
      end else if (m_cyc == LAT) begin
        m_cyc  = 0;
        m_done = 1;
        score(m_damage, m_hits);
      end else begin
        m_cyc++;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), (m_cyc != 0) ? 1 : 0);
      check("done", int'(done), m_done);
      check("slot_idx", int'(slot_idx), (m_cyc >= 1 && m_cyc <= N) ? m_cyc - 1 : 0);
      check("damage", int'(damage), m_damage);
      check("hit_count", int'(hit_count), m_hits);
    end
  end

  task automatic set_frame(input logic [7:0] c, input logic [15:0] col, input logic [7:0] mv);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      f_collide[i] = c[i];
      f_color[i]   = col[2*i +: 2];
      f_moving[i]  = mv[i];
    end
  endtask

  // Run one scan; returns clocks from start edge to done (or -1 on timeout).
  // dup_at re-pulses start at that scan cycle; chained means start is
  // already high (asserted during the previous done cycle).
  task automatic run_scan(input int dup_at, input bit chained, output int l);
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      start = (i == dup_at);
      if (done) begin
        l = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      f_collide[i] = 1'b0; f_color[i] = 2'd3; f_moving[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Idle after reset.
    repeat (20) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_damage", int'(damage), 0);
    check("rst_idx", int'(slot_idx), 0);

    // Slots 2 and 5 collide white.
    set_frame(8'h24, 16'hF3CF, 8'h00);
    run_scan(-1, 1'b0, lat);
    check("t2_latency", lat, 9);
    check("t2_damage", int'(damage), 100);
    check("t2_hits", int'(hit_count), 2);

    // All blue, still player.
    set_frame(8'hFF, 16'h5555, 8'h00);
    run_scan(-1, 1'b0, lat);
    check("t3_blue_damage", int'(damage), 0);
    check("t3_blue_hits", int'(hit_count), 0);

    // All orange, moving player.
    set_frame(8'hFF, 16'hAAAA, 8'hFF);
    run_scan(-1, 1'b0, lat);
    check("t3_orange_mv_damage", int'(damage), 0);
    check("t3_orange_mv_hits", int'(hit_count), 0);

    // All orange, still player: every slot hits.
    set_frame(8'hFF, 16'hAAAA, 8'h00);
    run_scan(-1, 1'b0, lat);
    check("t3_orange_still_hits", int'(hit_count), 8);

    // Mixed colours with per-slot motion: 6 hits, 300 raw.
    set_frame(8'hFF, 16'hE4E4, 8'hAA);
    run_scan(-1, 1'b0, lat);
    check("mix_hits", int'(hit_count), 6);
`ifdef DAMAGE_SATURATE_EN
    check("mix_damage", int'(damage), 255);
`else
    check("mix_damage", int'(damage), 44);
`endif

    // All white: 400 raw.
    set_frame(8'hFF, 16'h0000, 8'h00);
    run_scan(-1, 1'b0, lat);
    check("t4_hits", int'(hit_count), 8);
`ifdef DAMAGE_SATURATE_EN
    check("t4_damage", int'(damage), 255);
`else
    check("t4_damage", int'(damage), 144);
`endif

    // Start re-pulsed mid-scan, then start on the done cycle.
    set_frame(8'h24, 16'hF3CF, 8'h00);
    run_scan(3, 1'b0, lat);
    check("t5_dup_latency", lat, 9);
    check("t5_dup_damage", int'(damage), 100);
    start = 1'b1;
    run_scan(-1, 1'b1, lat);
    check("t5_chain_latency", lat, 9);
    check("t5_chain_damage", int'(damage), 100);
    check("t5_chain_hits", int'(hit_count), 2);

    // Reset mid-scan aborts immediately.
    set_frame(8'hFF, 16'h0000, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_damage", int'(damage), 0);
    check("t6_hits", int'(hit_count), 0);
    check("t6_idx", int'(slot_idx), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_after_damage", int'(damage), 0);
    check("t6_after_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
